// File: rtl/usbf_ahbm_dma_if.sv
// Signal bundle for usbf_ahbm_dma: transfer command, local word stream and AHB-Lite master bus.
interface usbf_ahbm_dma_if #(
   parameter int unsigned LEN_W = 10
);
   // Command channel
   logic             cmd_valid_i;
   logic             cmd_ready_o;
   logic             cmd_write_i;
   logic [31:0]      cmd_addr_i;
   logic [LEN_W-1:0] cmd_len_i;

   // Local word stream
   logic             wdat_valid_i;
   logic [31:0]      wdat_i;
   logic             wdat_ready_o;
   logic             rdat_ready_i;
   logic             rdat_valid_o;
   logic [31:0]      rdat_o;

   // Status
   logic             done_o;
   logic             err_o;
   logic             busy_o;

   // AHB-Lite master
   logic [31:0]      haddr_o;
   logic [1:0]       htrans_o;
   logic             hwrite_o;
   logic [2:0]       hsize_o;
   logic [2:0]       hburst_o;
   logic [31:0]      hwdata_o;
   logic             hready_i;
   logic [1:0]       hresp_i;
   logic [31:0]      hrdata_i;

   modport master (
      input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i,
      input  wdat_valid_i, wdat_i, rdat_ready_i,
      input  hready_i, hresp_i, hrdata_i,
      output cmd_ready_o, wdat_ready_o, rdat_valid_o, rdat_o,
      output done_o, err_o, busy_o,
      output haddr_o, htrans_o, hwrite_o, hsize_o, hburst_o, hwdata_o
   );

   modport slave (
      output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i,
      output wdat_valid_i, wdat_i, rdat_ready_i,
      output hready_i, hresp_i, hrdata_i,
      input  cmd_ready_o, wdat_ready_o, rdat_valid_o, rdat_o,
      input  done_o, err_o, busy_o,
      input  haddr_o, htrans_o, hwrite_o, hsize_o, hburst_o, hwdata_o
   );
endinterface

// File: rtl/usbf_ahbm_dma.sv
// AHB-Lite DMA master: moves a word stream to/from system memory with pipelined INCR beats.
// Beats are issued combinationally from the current data-side availability so that a write
// beat is only ever on the bus while its word sits at the head of the source.
module usbf_ahbm_dma #(
   parameter int unsigned LEN_W = 10
) (
   input logic             hclk_i,
   input logic             hrstn_i,
   usbf_ahbm_dma_if.master bus
);

   localparam logic [1:0] TransIdle   = 2'b00;
   localparam logic [1:0] TransNonseq = 2'b10;
   localparam logic [1:0] TransSeq    = 2'b11;
   localparam logic [1:0] RespOkay    = 2'b00;
   localparam logic [1:0] RespError   = 2'b01;

   typedef enum logic [1:0] {StIdle, StXfer, StDrain, StErr} state_e;

   state_e           state_q, state_d;
   logic [31:0]      addr_q;      // address of the next beat to be accepted
   logic [LEN_W-1:0] rem_q;       // beats not yet accepted
   logic             write_q;
   logic [1:0]       trans_q;     // htrans driven last cycle
   logic             pend_q;      // last cycle's beat was stalled and must be repeated
   logic             dphase_q;    // a data phase is outstanding
   logic [31:0]      hwdata_q;
   logic [31:0]      rdat_q;
   logic             rdat_valid_q;
   logic             done_q;
   logic             err_q;

   logic [1:0]       htrans;
   logic             cmd_acc;
   logic             len_zero;
   logic             avail;
   logic             beat_acc;
   logic             err_first;
   logic             rd_done;
   logic             dphase_d;
   logic             done_d;
   logic             err_d;

   assign cmd_acc   = (state_q == StIdle) && bus.cmd_valid_i;
   assign len_zero  = (bus.cmd_len_i == '0);
   assign avail     = write_q ? bus.wdat_valid_i : bus.rdat_ready_i;
   assign beat_acc  = (htrans != TransIdle) && bus.hready_i;
   assign err_first = dphase_q && !bus.hready_i && (bus.hresp_i == RespError);
   assign rd_done   = dphase_q && bus.hready_i && (bus.hresp_i == RespOkay) && !write_q &&
                      (state_q inside {StXfer, StDrain});
   assign dphase_d  = (state_q == StErr || err_first) ? 1'b0 :
                      (beat_acc || (dphase_q && !bus.hready_i));

   // State register.
   always_ff @(posedge hclk_i or negedge hrstn_i) begin
      if (!hrstn_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (cmd_acc && !len_zero) state_d = StXfer;
         end
         StXfer: begin
            if (err_first) begin
               state_d = StErr;
            end else if (beat_acc && rem_q == LEN_W'(1)) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (err_first) begin
               state_d = StErr;
            end else if (bus.hready_i) begin
               state_d = StIdle;
            end
         end
         StErr: begin
            if (bus.hready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Output decode: beat issue/hold, and completion pulses to be registered.
   always_comb begin
      htrans = TransIdle;
      done_d = 1'b0;
      err_d  = 1'b0;
      case (state_q)
         StIdle: begin
            done_d = cmd_acc && len_zero;
         end
         StXfer: begin
            // An ERROR first cycle cancels whatever beat would otherwise be on the bus.
            if (!err_first) begin
               if (pend_q) begin
                  htrans = trans_q;
               end else if (avail) begin
                  htrans = (trans_q == TransIdle || addr_q[9:0] == 10'd0) ? TransNonseq :
                                                                             TransSeq;
               end
            end
         end
         StDrain: begin
            done_d = bus.hready_i && !err_first;
         end
         StErr: begin
            err_d = bus.hready_i;
         end
         default: ;
      endcase
   end

   // Datapath: command latch, beat bookkeeping, write/read data and status pulses.
   always_ff @(posedge hclk_i or negedge hrstn_i) begin
      if (!hrstn_i) begin
         addr_q       <= 32'd0;
         rem_q        <= '0;
         write_q      <= 1'b0;
         trans_q      <= TransIdle;
         pend_q       <= 1'b0;
         dphase_q     <= 1'b0;
         hwdata_q     <= 32'd0;
         rdat_q       <= 32'd0;
         rdat_valid_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         trans_q      <= htrans;
         pend_q       <= (htrans != TransIdle) && !bus.hready_i;
         dphase_q     <= dphase_d;
         rdat_valid_q <= rd_done;
         done_q       <= done_d;
         err_q        <= err_d;
         if (rd_done) rdat_q <= bus.hrdata_i;
         if (cmd_acc && !len_zero) begin
            addr_q  <= bus.cmd_addr_i & ~32'h3;
            rem_q   <= bus.cmd_len_i;
            write_q <= bus.cmd_write_i;
         end else if (beat_acc) begin
            addr_q <= addr_q + 32'd4;
            rem_q  <= rem_q - LEN_W'(1);
            if (write_q) hwdata_q <= bus.wdat_i;
         end
      end
   end

   assign bus.htrans_o     = htrans;
   assign bus.haddr_o      = addr_q;
   assign bus.hwrite_o     = write_q;
   assign bus.hsize_o      = 3'b010;
   assign bus.hburst_o     = 3'b001;
   assign bus.hwdata_o     = hwdata_q;
   assign bus.cmd_ready_o  = (state_q == StIdle);
   assign bus.busy_o       = (state_q != StIdle);
   assign bus.wdat_ready_o = beat_acc && write_q;
   assign bus.rdat_valid_o = rdat_valid_q;
   assign bus.rdat_o       = rdat_q;
   assign bus.done_o       = done_q;
   assign bus.err_o        = err_q;

endmodule

// File: tb/tb_usbf_ahbm_dma.sv
// Directed bench for usbf_ahbm_dma: writes, waited reads, 1 KB boundary, ERROR abort,
// zero length, source stall and asynchronous reset mid-burst.
module tb_usbf_ahbm_dma;
   localparam int unsigned LEN_W = 10;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   usbf_ahbm_dma_if #(.LEN_W(LEN_W)) bus ();

   usbf_ahbm_dma #(.LEN_W(LEN_W)) dut (
      .hclk_i  (clk),
      .hrstn_i (rstn),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
      end
   endtask

   // Monitor state (written only by the monitor process).
   int          cyc = 0;
   int          acc_cyc = -1000;
   int          rdy_rise = -1;
   logic        p_rdy = 1'b1;
   logic [31:0] beat_addr [64];
   logic [1:0]  beat_trans [64];
   int          beat_cyc [64];
   int          nb = 0;
   logic [31:0] wd [64];
   int          nwd = 0;
   logic [31:0] rd [64];
   int          nrd = 0;
   int          rd_last = -1;
   int          n_done = 0, done_cyc = -1;
   int          n_err = 0, err_cyc = -1;
   int          n_pop = 0;
   int          n_act = 0;
   int          stab_viol = 0;
   int          n_errc = 0;
   logic [1:0]  errc_trans = 2'b00;
   logic        dph = 1'b0;
   logic [31:0] dph_addr = 32'd0;
   logic        p_wait = 1'b0;
   logic [1:0]  p_trans = 2'b00;
   logic [31:0] p_addr = 32'd0;

   // Sample everything on the falling edge, away from the DUT's active edge.
   always @(negedge clk) begin
      cyc++;
      if (bus.cmd_valid_i && bus.cmd_ready_o) acc_cyc = cyc;
      if (bus.cmd_ready_o && !p_rdy) rdy_rise = cyc;
      p_rdy = bus.cmd_ready_o;
      if (p_wait && bus.hresp_i != 2'b01 &&
          (bus.htrans_o != p_trans || bus.haddr_o != p_addr)) stab_viol++;
      if (bus.hresp_i == 2'b01 && !bus.hready_i) begin
         errc_trans = bus.htrans_o;
         n_errc++;
      end
      if (dph && bus.hready_i && bus.hwrite_o) begin
         if (nwd < 64) wd[nwd] = bus.hwdata_o;
         nwd++;
      end
      if (bus.htrans_o != 2'b00) n_act++;
      if (bus.htrans_o != 2'b00 && bus.hready_i) begin
         if (nb < 64) begin
            beat_addr[nb]  = bus.haddr_o;
            beat_trans[nb] = bus.htrans_o;
            beat_cyc[nb]   = cyc;
         end
         nb++;
         dph      = 1'b1;
         dph_addr = bus.haddr_o;
      end else if (bus.hready_i) begin
         dph = 1'b0;
      end
      p_wait  = (bus.htrans_o != 2'b00) && !bus.hready_i;
      p_trans = bus.htrans_o;
      p_addr  = bus.haddr_o;
      if (bus.rdat_valid_o) begin
         if (nrd < 64) rd[nrd] = bus.rdat_o;
         nrd++;
         rd_last = cyc;
      end
      if (bus.done_o) begin
         n_done++;
         done_cyc = cyc;
      end
      if (bus.err_o) begin
         n_err++;
         err_cyc = cyc;
      end
      if (bus.wdat_ready_o) n_pop++;
   end

   // Stimulus knobs, relative to the accept cycle of the current command.
   int          src_base = 0, src_n = 0, stall_idx = 99, stall_until = 0;
   int          wait_from = -100, wait_len = 0, err_at = -100;
   logic [31:0] src_data [8];

   // Advance one cycle and drive this cycle's slave/source inputs.
   task automatic tick();
      int rel;
      int idx;
      @(posedge clk);
      #1;
      rel = cyc + 1 - acc_cyc;
      idx = n_pop - src_base;
      bus.wdat_valid_i = (idx < src_n) && !(idx >= stall_idx && rel < stall_until);
      bus.wdat_i       = (idx >= 0 && idx < 8) ? src_data[idx] : 32'd0;
      bus.hready_i     = !((rel >= wait_from && rel < wait_from + wait_len) || rel == err_at);
      bus.hresp_i      = (rel == err_at || rel == err_at + 1) ? 2'b01 : 2'b00;
      bus.hrdata_i     = dph_addr ^ 32'h5A5A_0000;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic issue(input logic wr, input logic [31:0] addr, input int len, output int t);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_write_i = wr;
      bus.cmd_addr_i  = addr;
      bus.cmd_len_i   = LEN_W'(len);
      tick();
      bus.cmd_valid_i = 1'b0;
      t = acc_cyc;
   endtask

   initial begin
      int t, nb0, nwd0, nrd0, nd0, ne0, nact0, sv0, nerrc0;

      rstn             = 1'b0;
      bus.cmd_valid_i  = 1'b0;
      bus.cmd_write_i  = 1'b0;
      bus.cmd_addr_i   = 32'd0;
      bus.cmd_len_i    = '0;
      bus.wdat_valid_i = 1'b0;
      bus.wdat_i       = 32'd0;
      bus.rdat_ready_i = 1'b1;
      bus.hready_i     = 1'b1;
      bus.hresp_i      = 2'b00;
      bus.hrdata_i     = 32'd0;
      for (int i = 0; i < 8; i++) src_data[i] = 32'd0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_htrans", 32'(bus.htrans_o), 32'd0);
      check_eq("rst_haddr", bus.haddr_o, 32'd0);
      check_eq("rst_hwrite", 32'(bus.hwrite_o), 32'd0);
      check_eq("rst_hwdata", bus.hwdata_o, 32'd0);
      check_eq("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
      check_eq("rst_busy", 32'(bus.busy_o), 32'd0);
      check_eq("rst_done_err", {30'd0, bus.done_o, bus.err_o}, 32'd0);
      check_eq("rst_rdat_valid", 32'(bus.rdat_valid_o), 32'd0);
      check_eq("rst_wdat_ready", 32'(bus.wdat_ready_o), 32'd0);
      check_eq("rst_rdat", bus.rdat_o, 32'd0);
      check_eq("hsize_hburst", {26'd0, bus.hsize_o, bus.hburst_o}, {26'd0, 3'b010, 3'b001});
      rstn = 1'b1;
      run(2);

      // Write, zero-wait, 4 words at 0x1000_0000
      for (int i = 0; i < 4; i++) src_data[i] = 32'hCAFE_0000 + 32'(i);
      nb0 = nb; nwd0 = nwd; nd0 = n_done; src_base = n_pop; src_n = 4;
      issue(1'b1, 32'h1000_0000, 4, t);
      run(10);
      check_eq("wr_nbeats", 32'(nb - nb0), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("wr_addr%0d", i), beat_addr[nb0 + i], 32'h1000_0000 + 32'(4 * i));
         check_eq($sformatf("wr_trans%0d", i), 32'(beat_trans[nb0 + i]),
                  (i == 0) ? 32'd2 : 32'd3);
         check_eq($sformatf("wr_cyc%0d", i), 32'(beat_cyc[nb0 + i] - t), 32'(1 + i));
         check_eq($sformatf("wr_hwdata%0d", i), wd[nwd0 + i], 32'hCAFE_0000 + 32'(i));
      end
      check_eq("wr_pops", 32'(n_pop - src_base), 32'd4);
      check_eq("wr_ndone", 32'(n_done - nd0), 32'd1);
      check_eq("wr_done_cyc", 32'(done_cyc - t), 32'd6);
      check_eq("wr_ready_cyc", 32'(rdy_rise - t), 32'd6);

      // Read with 2 wait states during beat 2 address, 3 words at 0x2000_0010
      nb0 = nb; nrd0 = nrd; nd0 = n_done; sv0 = stab_viol;
      wait_from = 2; wait_len = 2;
      issue(1'b0, 32'h2000_0010, 3, t);
      run(10);
      wait_len = 0;
      check_eq("rdw_nbeats", 32'(nb - nb0), 32'd3);
      check_eq("rdw_addr1", beat_addr[nb0 + 1], 32'h2000_0014);
      check_eq("rdw_cyc1", 32'(beat_cyc[nb0 + 1] - t), 32'd4);
      check_eq("rdw_stable", 32'(stab_viol - sv0), 32'd0);
      check_eq("rdw_nrdat", 32'(nrd - nrd0), 32'd3);
      check_eq("rdw_rdat0", rd[nrd0], 32'h7A5A_0010);
      check_eq("rdw_rdat1", rd[nrd0 + 1], 32'h7A5A_0014);
      check_eq("rdw_rdat2", rd[nrd0 + 2], 32'h7A5A_0018);
      check_eq("rdw_ndone", 32'(n_done - nd0), 32'd1);
      check_eq("rdw_done_cyc", 32'(done_cyc - t), 32'd7);
      check_eq("rdw_last_rdat_cyc", 32'(rd_last - t), 32'd7);

      // 1 KB boundary, 3-word write at 0x0000_03FC
      for (int i = 0; i < 3; i++) src_data[i] = 32'hB000_0000 + 32'(i);
      nb0 = nb; nd0 = n_done; src_base = n_pop; src_n = 3;
      issue(1'b1, 32'h0000_03FC, 3, t);
      run(8);
      check_eq("kb_addr0", beat_addr[nb0], 32'h0000_03FC);
      check_eq("kb_addr1", beat_addr[nb0 + 1], 32'h0000_0400);
      check_eq("kb_trans1", 32'(beat_trans[nb0 + 1]), 32'd2);
      check_eq("kb_addr2", beat_addr[nb0 + 2], 32'h0000_0404);
      check_eq("kb_trans2", 32'(beat_trans[nb0 + 2]), 32'd3);
      check_eq("kb_ndone", 32'(n_done - nd0), 32'd1);

      // ERROR on beat 2 data phase of a 4-word read at 0x3000_0000
      nb0 = nb; nrd0 = nrd; nd0 = n_done; ne0 = n_err; nerrc0 = n_errc;
      err_at = 3;
      issue(1'b0, 32'h3000_0000, 4, t);
      run(10);
      err_at = -100;
      check_eq("err_first_seen", 32'(n_errc - nerrc0), 32'd1);
      check_eq("err_first_htrans", 32'(errc_trans), 32'd0);
      check_eq("err_nerr", 32'(n_err - ne0), 32'd1);
      check_eq("err_cyc", 32'(err_cyc - t), 32'd5);
      check_eq("err_nrdat", 32'(nrd - nrd0), 32'd1);
      check_eq("err_rdat0", rd[nrd0], 32'h6A5A_0000);
      check_eq("err_ndone", 32'(n_done - nd0), 32'd0);
      check_eq("err_nbeats", 32'(nb - nb0), 32'd2);
      check_eq("err_idle_after", 32'(bus.cmd_ready_o), 32'd1);

      // Zero length
      nb0 = nb; nd0 = n_done; nact0 = n_act;
      issue(1'b0, 32'h4444_0000, 0, t);
      run(4);
      check_eq("zl_ndone", 32'(n_done - nd0), 32'd1);
      check_eq("zl_done_cyc", 32'(done_cyc - t), 32'd1);
      check_eq("zl_no_active", 32'(n_act - nact0), 32'd0);

      // Source stall after 2 of 4 words
      for (int i = 0; i < 4; i++) src_data[i] = 32'h5000_0000 + 32'(i);
      nb0 = nb; nwd0 = nwd; nd0 = n_done; src_base = n_pop; src_n = 4;
      stall_idx = 2; stall_until = 5;
      issue(1'b1, 32'h4000_0000, 4, t);
      run(12);
      stall_idx = 99;
      check_eq("st_nbeats", 32'(nb - nb0), 32'd4);
      check_eq("st_trans1", 32'(beat_trans[nb0 + 1]), 32'd3);
      check_eq("st_trans2", 32'(beat_trans[nb0 + 2]), 32'd2);
      check_eq("st_addr2", beat_addr[nb0 + 2], 32'h4000_0008);
      check_eq("st_cyc2", 32'(beat_cyc[nb0 + 2] - t), 32'd5);
      check_eq("st_trans3", 32'(beat_trans[nb0 + 3]), 32'd3);
      for (int i = 0; i < 4; i++)
         check_eq($sformatf("st_hwdata%0d", i), wd[nwd0 + i], 32'h5000_0000 + 32'(i));
      check_eq("st_done_cyc", 32'(done_cyc - t), 32'd8);

      // Asynchronous reset mid-burst
      for (int i = 0; i < 8; i++) src_data[i] = 32'h6000_0000 + 32'(i);
      src_base = n_pop; src_n = 8;
      issue(1'b1, 32'h5000_0000, 8, t);
      run(2);
      check_eq("rb_active_before", 32'(bus.htrans_o != 2'b00), 32'd1);
      #2;
      rstn = 1'b0;
      #1;
      check_eq("rb_htrans", 32'(bus.htrans_o), 32'd0);
      check_eq("rb_busy", 32'(bus.busy_o), 32'd0);
      check_eq("rb_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
      check_eq("rb_haddr", bus.haddr_o, 32'd0);
      check_eq("rb_wdat_ready", 32'(bus.wdat_ready_o), 32'd0);
      nd0 = n_done; ne0 = n_err;
      run(2);
      rstn = 1'b1;
      run(5);
      check_eq("rb_no_done_err", 32'((n_done - nd0) + (n_err - ne0)), 32'd0);
      check_eq("rb_busy_after", 32'(bus.busy_o), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #100000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule
